// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: I2C slave front-end that turns bus transactions
// into single-cycle strobes for a downstream GPIO register port.
module i2c_reg_bridge #(
    parameter logic [6:0] DEV_ADDR   = 7'h30,
    parameter logic [3:0] PORT_ID    = 4'h0,
    parameter int         FILTER_LEN = 3
) (
    input  logic        SYSCLK,
    input  logic        RESET_N,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic        PORT_CS,
    output logic [15:0] OFFSET_SEL,
    output logic        RD_WR,
    output logic [7:0]  WR_DATA,
    input  logic [7:0]  RD_DATA
);

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        DEVACK,
        PTR,
        PTRACK,
        WRDATA,
        WRACK,
        RDLOAD,
        RDDATA,
        RDACK,
        WAITSTOP
    } state_t;

    localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic [2:0] scl_cnt;
    logic [2:0] sda_cnt;
    logic       scl_f;
    logic       sda_f;
    logic       scl_d;
    logic       sda_d;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic       port_hit;

    state_t     state;
    state_t     state_n;
    logic [3:0] bit_cnt;
    logic [3:0] bit_n;
    logic [6:0] rx_sr;
    logic [6:0] rx_n;
    logic [7:0] tx_sr;
    logic [7:0] tx_n;
    logic [7:0] ptr;
    logic [7:0] ptr_n;
    logic [1:0] ld_cnt;
    logic [1:0] ld_n;
    logic       rw_q;
    logic       rw_n;
    logic       sda_oe_q;
    logic       oe_n;
    logic       port_cs_q;
    logic       cs_n;
    logic       rd_wr_q;
    logic       rdwr_n;
    logic [7:0] wr_data_q;
    logic [7:0] wdat_n;
    logic       inc_pend;
    logic       inc_n;
    logic [7:0] byte_in;

    // Two-flop synchronizers on the raw pins (bus idles high)
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SCL_IN};
            sda_sync <= {sda_sync[0], SDA_IN};
        end
    end

    // Glitch filter: a new level is taken once it has held FILTER_LEN cycles
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLT_MAX) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLT_MAX) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    // Previous filtered levels for edge and START/STOP detection
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign port_hit  = (ptr[7:4] == PORT_ID);

    // State and datapath registers
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= 8'hFF;
            ptr       <= 8'h00;
            ld_cnt    <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            port_cs_q <= 1'b0;
            rd_wr_q   <= 1'b1;
            wr_data_q <= 8'h00;
            inc_pend  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_n;
            rx_sr     <= rx_n;
            tx_sr     <= tx_n;
            ptr       <= ptr_n;
            ld_cnt    <= ld_n;
            rw_q      <= rw_n;
            sda_oe_q  <= oe_n;
            port_cs_q <= cs_n;
            rd_wr_q   <= rdwr_n;
            wr_data_q <= wdat_n;
            inc_pend  <= inc_n;
        end
    end

    // Next-state, bit shifting, ACK driving and port strobes
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        rx_n    = rx_sr;
        tx_n    = tx_sr;
        ptr_n   = ptr;
        ld_n    = ld_cnt;
        rw_n    = rw_q;
        oe_n    = sda_oe_q;
        cs_n    = 1'b0;
        rdwr_n  = 1'b1;
        wdat_n  = wr_data_q;
        inc_n   = 1'b0;
        byte_in = {rx_sr, sda_f};

        if (inc_pend) begin
            ptr_n[3:0] = ptr[3:0] + 4'd1;
        end

        if (start_det) begin
            state_n = DEVADDR;
            bit_n   = '0;
        end else if (stop_det) begin
            state_n = IDLE;
            bit_n   = '0;
        end else begin
            case (state)
                DEVADDR: begin
                    if (scl_rise) begin
                        rx_n  = byte_in[6:0];
                        bit_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rw_n = byte_in[0];
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_n = DEVACK;
                            end else begin
                                state_n = WAITSTOP;
                            end
                        end
                    end
                end
                DEVACK, PTRACK, WRACK: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        oe_n = 1'b1;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        oe_n  = 1'b0;
                        bit_n = '0;
                        if (state == DEVACK) begin
                            state_n = PTR;
                        end else begin
                            state_n = WRDATA;
                        end
                    end else if (scl_rise) begin
                        bit_n = 4'd9;
                        if (state == DEVACK && rw_q) begin
                            state_n = RDLOAD;
                            ld_n    = '0;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        rx_n  = byte_in[6:0];
                        bit_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr_n   = byte_in;
                            state_n = PTRACK;
                        end
                    end
                end
                WRDATA: begin
                    if (scl_rise) begin
                        rx_n  = byte_in[6:0];
                        bit_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            wdat_n  = byte_in;
                            cs_n    = port_hit;
                            rdwr_n  = 1'b0;
                            inc_n   = 1'b1;
                            state_n = WRACK;
                        end
                    end
                end
                RDLOAD: begin
                    ld_n = ld_cnt + 2'd1;
                    if (ld_cnt == 2'd0) begin
                        cs_n = port_hit;
                    end else if (ld_cnt == 2'd3) begin
                        tx_n    = port_hit ? RD_DATA : 8'hFF;
                        bit_n   = '0;
                        state_n = RDDATA;
                    end
                end
                RDDATA: begin
                    if (scl_fall) begin
                        oe_n = ~tx_sr[7];
                        tx_n = {tx_sr[6:0], 1'b1};
                    end else if (scl_rise) begin
                        bit_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n = RDACK;
                        end
                    end
                end
                RDACK: begin
                    if (scl_fall) begin
                        oe_n = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_f) begin
                            ptr_n[3:0] = ptr[3:0] + 4'd1;
                            ld_n       = '0;
                            state_n    = RDLOAD;
                        end else begin
                            state_n = WAITSTOP;
                        end
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    assign SDA_OE     = sda_oe_q;
    assign PORT_CS    = port_cs_q;
    assign RD_WR      = rd_wr_q;
    assign WR_DATA    = wr_data_q;
    assign OFFSET_SEL = 16'd1 << ptr[3:0];

endmodule
